// File: rtl/pipe_push.sv
// rtl/pipe_push.sv - producer-side push adapter with 2-entry elastic buffer
//
// Converts an upstream valid/ready stream into a pipe push interface
// (data_i / valid_i / full). A main register feeds the pipe and a skid
// register absorbs one extra word so that in_ready is a pure decode of
// state and flush, never combinationally dependent on push_full.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   flush           synchronous discard of all buffered entries
//   in_valid/in_data/in_ready     upstream stream
//   push_valid/push_data          to pipe valid_i / data_i
//   push_full       from pipe full; blocks a push while high
//   occupancy       buffered entries 0..2 (equals state encoding)
//   stall_cycles    cycles with a blocked push (PIPE_PUSH_STATS_EN)
//   push_count      completed pushes (PIPE_PUSH_STATS_EN)
//
// Optional feature macro: PIPE_PUSH_STATS_EN. When undefined the two
// statistics ports are tied to 0 and no counter flops exist.

module pipe_push #(
    parameter int DATA_SIZE = 32,
    parameter int STAT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [DATA_SIZE-1:0] in_data,
    output logic                 in_ready,
    output logic                 push_valid,
    output logic [DATA_SIZE-1:0] push_data,
    input  logic                 push_full,
    output logic [1:0]           occupancy,
    output logic [STAT_W-1:0]    stall_cycles,
    output logic [STAT_W-1:0]    push_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;
    logic [DATA_SIZE-1:0] main_q;
    logic [DATA_SIZE-1:0] skid_q;

    logic accept;
    logic drain;
    logic load_main;
    logic main_from_skid;
    logic load_skid;

    assign accept = in_valid & in_ready;
    assign drain  = push_valid & ~push_full;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; flush wins over every other transition
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: if (accept) state_nxt = HALF;
                HALF: begin
                    if (accept && !drain)      state_nxt = FULL;
                    else if (!accept && drain) state_nxt = EMPTY;
                end
                FULL:  if (drain) state_nxt = HALF;
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Output / datapath-control decode
    always_comb begin
        in_ready       = (state != FULL) & ~flush;
        push_valid     = (state != EMPTY);
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: load_main = accept;
            HALF: begin
                // Accept while draining replaces main directly; accept while
                // blocked parks the new word behind main in the skid slot.
                load_main = accept & drain;
                load_skid = accept & ~drain;
            end
            FULL: begin
                load_main      = drain & ~flush;
                main_from_skid = drain & ~flush;
            end
            default: ;
        endcase
    end

    // Main and skid data registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= main_from_skid ? skid_q : in_data;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign push_data = main_q;
    assign occupancy = state;

`ifdef PIPE_PUSH_STATS_EN
    logic [STAT_W-1:0] stall_q;
    logic [STAT_W-1:0] count_q;

    // Saturating counters, deliberately not cleared by flush
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            count_q <= '0;
        end else begin
            if (push_valid && push_full && !flush && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (drain && (count_q != '1)) begin
                count_q <= count_q + 1'b1;
            end
        end
    end

    assign stall_cycles = stall_q;
    assign push_count   = count_q;
`else
    assign stall_cycles = '0;
    assign push_count   = '0;
`endif

endmodule

// File: tb/tb_pipe_push.sv
// tb/tb_pipe_push.sv - self-checking bench for pipe_push

module tb_pipe_push;

    localparam int DW = 32;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          push_valid;
    logic [DW-1:0] push_data;
    logic          push_full;
    logic [1:0]    occupancy;
    logic [SW-1:0] stall_cycles;
    logic [SW-1:0] push_count;

    int checks;
    int errors;

    pipe_push #(.DATA_SIZE(DW), .STAT_W(SW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .push_valid   (push_valid),
        .push_data    (push_data),
        .push_full    (push_full),
        .occupancy    (occupancy),
        .stall_cycles (stall_cycles),
        .push_count   (push_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          iv;
        logic [DW-1:0] d;
        logic          pf;
        logic          fl;
        logic          rdy;  // in_ready during the cycle
        logic          pv;   // push_valid after the edge
        logic [DW-1:0] pd;   // push_data after the edge (checked when pv)
        logic [1:0]    occ;  // occupancy after the edge
    } vec_t;

    vec_t vt[17];

`ifdef PIPE_PUSH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic pf, input logic fl);
        in_valid  = iv;
        in_data   = d;
        push_full = pf;
        flush     = fl;
    endtask

    task automatic do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);

        //         iv  data      pf fl  rdy pv  pd        occ
        // streaming
        vt[0]  = '{1'b1, 32'h11, 1'b0, 1'b0, 1'b1, 1'b1, 32'h11, 2'd1};
        vt[1]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b1, 1'b1, 32'h22, 2'd1};
        vt[2]  = '{1'b1, 32'h33, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 2'd1};
        vt[3]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
        // back-pressure fill and release
        vt[4]  = '{1'b1, 32'hA0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 2'd1};
        vt[5]  = '{1'b1, 32'hA1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hA0, 2'd2};
        vt[6]  = '{1'b1, 32'hA2, 1'b1, 1'b0, 1'b0, 1'b1, 32'hA0, 2'd2};
        vt[7]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b0, 1'b1, 32'hA1, 2'd1};
        vt[8]  = '{1'b1, 32'hA2, 1'b0, 1'b0, 1'b1, 1'b1, 32'hA2, 2'd1};
        vt[9]  = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
        // flush while FULL
        vt[10] = '{1'b1, 32'hB0, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0, 2'd1};
        vt[11] = '{1'b1, 32'hB1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hB0, 2'd2};
        vt[12] = '{1'b1, 32'hB2, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0};
        // push_full ignored while EMPTY; flush blocks accept from EMPTY
        vt[13] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b1, 1'b0, 32'h00, 2'd0};
        vt[14] = '{1'b1, 32'hC0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0};
        vt[15] = '{1'b1, 32'hC1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC1, 2'd1};
        // flush coinciding with a drain
        vt[16] = '{1'b0, 32'h00, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 2'd0};

        // reset state
        #2;
        chk("reset_push_valid", 32'(push_valid), 32'd0);
        chk("reset_push_data", push_data, 32'd0);
        chk("reset_occupancy", 32'(occupancy), 32'd0);
        chk("reset_push_count", 32'(push_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_reset", 32'(in_ready), 32'd1);

        for (int i = 0; i < 17; i++) begin
            drive(vt[i].iv, vt[i].d, vt[i].pf, vt[i].fl);
            #1;
            chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].rdy));
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_push_valid", i), 32'(push_valid), 32'(vt[i].pv));
            chk($sformatf("v%0d_occupancy", i), 32'(occupancy), 32'(vt[i].occ));
            if (vt[i].pv) begin
                chk($sformatf("v%0d_push_data", i), push_data, vt[i].pd);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        #1;
        chk("in_ready_after_flush", 32'(in_ready), 32'd1);

        // stall hold: 0x55 buffered, push_full high for 5 cycles
        do_reset();
        drive(1'b1, 32'h55, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("stall%0d_push_valid", k), 32'(push_valid), 32'd1);
            chk($sformatf("stall%0d_push_data", k), push_data, 32'h55);
        end
        chk("stall_cycles", 32'(stall_cycles), STATS ? 32'd5 : 32'd0);
        chk("stall_push_count", 32'(push_count), 32'd0);
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("stall_release_occ", 32'(occupancy), 32'd0);
        chk("stall_release_count", 32'(push_count), STATS ? 32'd1 : 32'd0);

        // async reset mid-stream with one word buffered
        drive(1'b1, 32'h77, 1'b1, 1'b0);
        @(posedge clk);
        @(negedge clk);
        drive(1'b0, '0, 1'b1, 1'b0);
        chk("pre_reset_occ", 32'(occupancy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_push_valid", 32'(push_valid), 32'd0);
        chk("async_rst_occ", 32'(occupancy), 32'd0);
        chk("async_rst_push_data", push_data, 32'd0);
        chk("async_rst_push_count", 32'(push_count), 32'd0);
        chk("async_rst_stall", 32'(stall_cycles), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // saturation: 20 drains into a 4-bit counter
        for (int k = 0; k < 20; k++) begin
            drive(1'b1, 32'(k), 1'b0, 1'b0);
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("sat%0d_push_data", k), push_data, 32'(k));
        end
        drive(1'b0, '0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        chk("sat_push_count", 32'(push_count), STATS ? 32'd15 : 32'd0);
        chk("sat_stall_cycles", 32'(stall_cycles), 32'd0);
        chk("sat_occ", 32'(occupancy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
